// File: rtl/dds_pwm_bank_if.sv
// Avalon-MM register bus for dds_pwm_bank.
// A write is accepted in any cycle where chipselect=1 and write_n=0 (no wait states); readdata is combinational from address.
interface dds_pwm_bank_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/dds_pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one period counter, with shadowed PERIOD/DUTY registers.
// Define DDS_PWM_IRQ_EN to build the STATUS.WRAP flag, CTRL.IRQ_EN and the irq output.
module dds_pwm_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    dds_pwm_bank_if.slave     bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_DUTY0  = 4'd4;

    logic             wr_en;
    logic [CNT_W-1:0] wr_val;
    logic             unused_wdata;
    logic             en;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_sh  [NUM_CH];
    logic [CNT_W-1:0] duty_act [NUM_CH];
    logic             wrap_cycle;
    logic             load_act;
    logic [31:0]      ctrl_rd;
    logic [31:0]      status_rd;

    function automatic logic duty_hit(input logic [3:0] addr, input int ch);
        return addr == (ADDR_DUTY0 + 4'(ch));
    endfunction

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign wr_val       = bus.writedata[CNT_W-1:0];
    assign unused_wdata = ^bus.writedata;

    // While disabled the actives track the shadows every cycle, so enabling starts from fresh values.
    assign wrap_cycle = en && (cnt == period_act);
    assign load_act   = !en || wrap_cycle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en <= 1'b0;
        end else if (wr_en && (bus.address == ADDR_CTRL)) begin
            en <= bus.writedata[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_sh <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (wr_en) begin
            if (bus.address == ADDR_PERIOD) begin
                period_sh <= wr_val;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (duty_hit(bus.address, i)) begin
                    duty_sh[i] <= wr_val;
                end
            end
        end
    end

    // A shadow written in the wrap cycle itself is loaded one period later: the actives see the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_act <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= '0;
            end
        end else if (load_act) begin
            period_act <= period_sh;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= duty_sh[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || (cnt == period_act)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // duty=0 never matches cnt<duty; duty>period always matches, giving constant low/high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= en && (cnt < duty_act[i]);
            end
        end
    end

`ifdef DDS_PWM_IRQ_EN
    logic irq_en;
    logic wrap_flag;
    logic irq_q;
    logic wrap_clr;

    assign wrap_clr = wr_en && (bus.address == ADDR_STATUS) && bus.writedata[0];

    // A wrap coinciding with the W1C keeps the flag set so no wrap event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en    <= 1'b0;
            wrap_flag <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en && (bus.address == ADDR_CTRL)) begin
                irq_en <= bus.writedata[1];
            end
            if (wrap_cycle) begin
                wrap_flag <= 1'b1;
            end else if (wrap_clr) begin
                wrap_flag <= 1'b0;
            end
            irq_q <= wrap_flag && irq_en;
        end
    end

    assign irq       = irq_q;
    assign ctrl_rd   = {30'd0, irq_en, en};
    assign status_rd = {31'd0, wrap_flag};
`else
    assign irq       = 1'b0;
    assign ctrl_rd   = {31'd0, en};
    assign status_rd = '0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL:   bus.readdata = ctrl_rd;
            ADDR_PERIOD: bus.readdata = 32'(period_sh);
            ADDR_STATUS: bus.readdata = status_rd;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (duty_hit(bus.address, i)) begin
                        bus.readdata = 32'(duty_sh[i]);
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/dds_pwm_bank.md
DDS_PWM_BANK -- requirements
Module: dds_pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 2, number of PWM channels; legal range 1..12.
REQ-002 Parameter CNT_W, default 16, width of the counter, period and duty registers; legal range 2..32.
REQ-003 Port clk, input, 1 bit, sole clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port address, input, 4 bits, Avalon-MM word address.
REQ-006 Port chipselect, input, 1 bit, slave select.
REQ-007 Port write_n, input, 1 bit, active-low write strobe.
REQ-008 Port writedata, input, 32 bits, write data; bits above CNT_W are ignored.
REQ-009 Port readdata, output, 32 bits, combinational read data, zero-extended.
REQ-010 Port pwm_out, output, NUM_CH bits, registered PWM outputs, one bit per channel.
REQ-011 Port irq, output, 1 bit, level interrupt request.

Function
REQ-012 Register map SHALL be: 0 CTRL (bit0 EN, bit1 IRQ_EN); 1 PERIOD; 2 STATUS (bit0 WRAP); 3 reserved; 4+i DUTY[i] for i < NUM_CH.
REQ-013 A write SHALL occur when chipselect=1 and write_n=0; writes to reserved or unused addresses have no effect.
REQ-014 readdata SHALL return CTRL, shadow PERIOD, STATUS or shadow DUTY[i] for the current address, and 0 for reserved or unused addresses; reads have no side effects.
REQ-015 PERIOD and DUTY writes SHALL update shadow registers only; active copies are loaded from the shadows at the wrap cycle.
REQ-016 When EN=1, counter cnt SHALL increment by 1 per clock; when cnt==period_act, the next value SHALL be 0 (the wrap cycle), giving a period of period_act+1 clocks.
REQ-017 In the wrap cycle, period_act and every duty_act[i] SHALL load from their shadows, taking effect from cnt=0.
REQ-018 pwm_out[i] SHALL be registered as EN && (cnt < duty_act[i]), one clock after the counter value it reflects.
REQ-019 duty_act[i]=0 SHALL give a constant low output; duty_act[i] > period_act SHALL give a constant high output.
REQ-020 PERIOD=0 SHALL hold cnt at 0, making every cycle a wrap cycle.
REQ-021 When EN=0, cnt SHALL be held at 0, pwm_out SHALL be 0 on the next clock, and the active registers SHALL load from the shadows every cycle.
REQ-022 On an EN 0->1 write, counting SHALL start at cnt=0 on the following cycle.
REQ-023 A write to the same shadow in the wrap cycle SHALL NOT be seen until the next wrap.

Reset
REQ-024 On reset_n=0, asynchronously: CTRL=0, STATUS=0, cnt=0, all shadow and active registers=0, pwm_out=0, irq=0.
REQ-025 A reset asserted mid-period SHALL abort the period immediately; after release the block is idle with EN=0.

Configuration
REQ-026 With macro DDS_PWM_IRQ_EN defined, STATUS.WRAP SHALL set in every wrap cycle while EN=1.
REQ-027 With DDS_PWM_IRQ_EN defined, writing STATUS with bit0=1 SHALL clear WRAP; a set in the same cycle SHALL win over the clear.
REQ-028 With DDS_PWM_IRQ_EN defined, irq SHALL be registered as WRAP && IRQ_EN.
REQ-029 Without DDS_PWM_IRQ_EN, the irq port SHALL remain and read constant 0, STATUS SHALL read 0, and CTRL bit1 SHALL read 0 and be unwritable.

Verification
REQ-030 NUM_CH=2, PERIOD=9, DUTY0=3, DUTY1=10, EN=1 -> pwm_out[0] high 3 of every 10 clocks; pwm_out[1] constant high.
REQ-031 While running, change DUTY0 3->7 mid-period -> the old duty completes; the 7-clock high phase starts at the first cnt=0 after the wrap.
REQ-032 PERIOD=0, DUTY0=1, DUTY1=0 -> pwm_out=2'b01 constant; with IRQ_EN set, irq asserts each cycle.
REQ-033 IRQ build: IRQ_EN=1, PERIOD=4 -> irq rises after the first wrap; a W1C write to STATUS coinciding with the next wrap leaves WRAP=1.
REQ-034 Assert reset_n=0 while cnt=5 -> pwm_out, irq and readdata of all registers are 0 immediately, asynchronously.
REQ-035 Write EN=0 mid-period -> pwm_out=0 on the next clock; a reads/writes sweep of addresses 3 and 4+NUM_CH..15 reads 0 with no side effect.
